// File: rtl/sync_arb_pkg.sv
// Shared types and constants for the round-robin signal arbiter.
package sync_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned HOLD_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_signal_arbiter_if.sv
// Requester-side bus of the arbiter: requests, grant length and grant outputs.
interface sync_signal_arbiter_if
  import sync_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned HOLD_W  = HOLD_W_DEF
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [HOLD_W-1:0]  hold_len;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               enable_out;
  logic               busy;

  modport master (
    output req, hold_len,
    input  gnt, gnt_id, enable_out, busy
  );

  modport slave (
    input  req, hold_len,
    output gnt, gnt_id, enable_out, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above rr_ptr, wrapping.
module rr_pick
  import sync_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets 0..NUM_REQ-1 from rr_ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sync_signal_arbiter.sv
// Round-robin owner of a shared enable register; one requester at a time for a
// latched number of cycles. Define SYNC_ARB_GAP_EN to insert one deasserted
// cycle between consecutive grants; otherwise handoffs are back-to-back.
module sync_signal_arbiter
  import sync_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned HOLD_W  = HOLD_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sync_signal_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;

  logic               pick_valid_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               launch_c;
  logic               grant_end_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .valid   (pick_valid_c),
    .idx     (pick_idx_c)
  );

  // Next state, grant counter, rotation pointer and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    enable_d    = enable_q;
    busy_d      = busy_q;
    launch_c    = 1'b0;
    grant_end_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        launch_c = pick_valid_c;
      end
      ST_GRANT: begin
        if ((cnt_q == HOLD_W'(1)) || !bus.req[gnt_id_q]) begin
          grant_end_c = 1'b1;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
`ifdef SYNC_ARB_GAP_EN
      ST_GAP: begin
        launch_c = pick_valid_c;
        if (!pick_valid_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Grant end: either park in GAP for one cycle or hand off on this edge.
    if (grant_end_c) begin
`ifdef SYNC_ARB_GAP_EN
      state_d  = ST_GAP;
      gnt_d    = '0;
      gnt_id_d = '0;
      enable_d = 1'b0;
      busy_d   = 1'b1;
`else
      launch_c = pick_valid_c;
      if (!pick_valid_c) begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
`endif
    end

    // New grant: latch length (0 acts as 1) and move the pointer past the winner.
    if (launch_c) begin
      state_d  = ST_GRANT;
      gnt_d    = NUM_REQ'(1) << pick_idx_c;
      gnt_id_d = pick_idx_c;
      enable_d = 1'b1;
      busy_d   = 1'b1;
      cnt_d    = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
      rr_ptr_d = (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.enable_out = enable_q;
  assign bus.busy       = busy_q;

endmodule
